// File: rtl/sqrt_core.sv
// sqrt_core: restoring square-root stage; define SQRT_FIXED_LATENCY_EN to route specials through CALC for fixed 13-cycle latency
module sqrt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        n_valid,
  input  logic        is_num,
  input  logic        is_nan,
  input  logic        is_pinf,
  input  logic        is_ninf,
  input  logic        sign_in,
  input  logic [6:0]  exp_in,
  input  logic [10:0] mant_in,
  output logic        busy,
  output logic        r_valid,
  output logic        res_nan,
  output logic        res_inf,
  output logic        res_zero,
  output logic        res_sign,
  output logic [6:0]  res_exp,
  output logic [11:0] res_mant,
  output logic        res_sticky,
  output logic        overrun
);
  localparam int ITER = 12;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t            state_q, state_d;
  logic [2*ITER-1:0] rad_q, rad_d;
  logic [ITER+1:0]   rem_q, rem_d, diff;
  logic [ITER-1:0]   q_q, q_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        exp_q, exp_d;
  logic [ITER+3:0]   cat;
  logic num_q, num_d, nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, sign_q, sign_d, ovr_q, ovr_d;
  logic ge, op_nan, op_inf, op_num, accept;
  always_comb begin
    cat     = {rem_q, rad_q[2*ITER-1 -: 2]};
    ge      = cat >= {2'b00, q_q, 2'b01};
    diff    = cat[ITER+1:0] - {q_q, 2'b01};
    op_nan  = is_nan | is_ninf | (is_num & sign_in);
    op_inf  = ~op_nan & is_pinf;
    op_num  = ~op_nan & ~op_inf & is_num;
    accept  = enable & n_valid & (state_q == IDLE);
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    num_d   = num_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    sign_d  = sign_q;
    ovr_d   = ovr_q | (enable & n_valid & (state_q != IDLE));
    if (accept) begin
      nan_d  = op_nan;
      inf_d  = op_inf;
      zero_d = ~op_nan & ~op_inf & ~is_num;
      sign_d = ~op_nan & ~op_inf & ~is_num & sign_in;
      exp_d  = op_num ? {exp_in[6], exp_in[6:1]} : 7'd0;
      rad_d  = ~op_num ? '0 : exp_in[0] ? {mant_in, 13'd0} : {1'b0, mant_in, 12'd0};
      rem_d  = '0;
      q_d    = '0;
      cnt_d  = 4'(ITER);
      num_d  = op_num;
`ifdef SQRT_FIXED_LATENCY_EN
      state_d = CALC;
`else
      state_d = op_num ? CALC : DONE;
`endif
    end else if (enable && state_q == CALC) begin
      if (num_q) begin
        rem_d = ge ? diff : cat[ITER+1:0];
        q_d   = {q_q[ITER-2:0], ge};
        rad_d = rad_q << 2;
      end
      cnt_d   = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? DONE : CALC;
    end else if (enable && state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      num_q   <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      num_q   <= num_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      ovr_q   <= ovr_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign r_valid    = enable & (state_q == DONE);
  assign res_nan    = nan_q;
  assign res_inf    = inf_q;
  assign res_zero   = zero_q;
  assign res_sign   = sign_q;
  assign res_exp    = exp_q;
  assign res_mant   = q_q;
  assign res_sticky = |rem_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_sqrt_core.sv
// tb_sqrt_core: randomized scoreboard bench for sqrt_core against an arithmetic square-root model
module tb_sqrt_core;
`ifdef SQRT_FIXED_LATENCY_EN
  localparam int SPL = 12;
`else
  localparam int SPL = 0;
`endif
  typedef struct {
    bit nan, inf, zero, sign;
    bit [6:0] e;
    bit [11:0] m;
    bit st;
    int lat;
    int due;
  } exp_t;
  logic clk = 0, rst = 1, enable = 1, n_valid = 0;
  logic is_num = 0, is_nan = 0, is_pinf = 0, is_ninf = 0, sign_in = 0;
  logic [6:0] exp_in = 0;
  logic [10:0] mant_in = 0;
  logic busy, r_valid, res_nan, res_inf, res_zero, res_sign, res_sticky, overrun;
  logic [6:0] res_exp;
  logic [11:0] res_mant;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t sb[$];

  sqrt_core dut (
    .clk(clk), .rst(rst), .enable(enable), .n_valid(n_valid),
    .is_num(is_num), .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .busy(busy), .r_valid(r_valid), .res_nan(res_nan), .res_inf(res_inf),
    .res_zero(res_zero), .res_sign(res_sign), .res_exp(res_exp),
    .res_mant(res_mant), .res_sticky(res_sticky), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input bit num, nan, pinf, ninf, sgn, input int e, input bit [10:0] m);
    exp_t x;
    longint r, q;
    int e2;
    x = '{default: 0};
    x.lat = SPL;
    if (nan || ninf || (num && sgn)) x.nan = 1;
    else if (pinf) x.inf = 1;
    else if (!num) begin
      x.zero = 1;
      x.sign = sgn;
    end else begin
      e2 = e - (e & 1);
      r = longint'(m) << (12 + (e & 1));
      q = longint'($sqrt(real'(r)));
      while (q * q > r) q--;
      while ((q + 1) * (q + 1) <= r) q++;
      x.e = 7'(e2 / 2);
      x.m = 12'(q);
      x.st = (q * q != r);
      x.lat = 12;
    end
    return x;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t x;
    if (!rst && r_valid) begin
      if (sb.size() == 0) chk("unexpected_r_valid", r_valid, 0);
      else begin
        x = sb.pop_front();
        chk("res_nan", res_nan, x.nan);
        chk("res_inf", res_inf, x.inf);
        chk("res_zero", res_zero, x.zero);
        chk("res_sign", res_sign, x.sign);
        chk("res_exp", res_exp, x.e);
        chk("res_mant", res_mant, x.m);
        chk("res_sticky", res_sticky, x.st);
        chk("r_valid_cycle", cyc, x.due);
      end
    end
  end

  task automatic send(input bit num, nan, pinf, ninf, sgn, input int e, input bit [10:0] m,
                      input bit expect_it, input int stall_len);
    exp_t x;
    x = model(num, nan, pinf, ninf, sgn, e, m);
    x.due = cyc + 1 + x.lat + stall_len;
    if (expect_it) sb.push_back(x);
    {is_num, is_nan, is_pinf, is_ninf, sign_in} = {num, nan, pinf, ninf, sgn};
    exp_in = 7'(e);
    mant_in = m;
    n_valid = 1;
    @(posedge clk);
    #1 n_valid = 0;
  endtask

  task automatic stall(input int at, input int len);
    repeat (at) begin
      @(posedge clk);
      #1;
    end
    enable = 0;
    repeat (len) @(posedge clk);
    #1 enable = 1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 40) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic op(input bit num, nan, pinf, ninf, sgn, input int e, input bit [10:0] m,
                    input int at, input int len);
    send(num, nan, pinf, ninf, sgn, e, m, 1, len);
    if (len > 0) stall(at, len);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_r_valid", r_valid, 0);
    chk("reset_flags", {res_nan, res_inf, res_zero, res_sign, res_sticky, overrun}, 0);
    chk("reset_exp_mant", {res_exp, res_mant}, 0);
    op(1, 0, 0, 0, 0, 2, 11'h400, 0, 0);
    op(1, 0, 0, 0, 0, 1, 11'h400, 0, 0);
    op(1, 0, 0, 0, 1, 0, 11'h400, 0, 0);
    op(0, 0, 1, 0, 0, 0, 11'h000, 0, 0);
    op(0, 0, 0, 0, 1, 0, 11'h000, 0, 0);
    op(0, 1, 0, 0, 0, 5, 11'h5a5, 0, 0);
    op(0, 0, 0, 1, 1, 0, 11'h000, 0, 0);
    op(1, 0, 0, 0, 0, -24, 11'h7ff, 0, 0);
    op(1, 0, 0, 0, 0, -23, 11'h7ff, 0, 0);
    op(1, 0, 0, 0, 0, 15, 11'h7ff, 0, 0);
    op(1, 0, 0, 0, 0, 14, 11'h400, 0, 0);
    op(1, 0, 0, 0, 0, 7, 11'h6a1, 4, 5);
    op(1, 0, 0, 0, 0, -5, 11'h533, 12, 3);
    op(0, 0, 1, 0, 0, 0, 11'h000, SPL, 4);
    chk("overrun_clear", overrun, 0);
    send(1, 0, 0, 0, 0, 3, 11'h480, 1, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    send(1, 0, 0, 0, 0, 2, 11'h400, 0, 0);
    chk("overrun_set", overrun, 1);
    wait_idle();
    chk("overrun_sticky", overrun, 1);
    send(1, 0, 0, 0, 0, 6, 11'h777, 1, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    chk("rst_busy", busy, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_flags", {res_nan, res_inf, res_zero, res_sign, res_sticky, overrun}, 0);
    chk("rst_exp_mant", {res_exp, res_mant}, 0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    op(1, 0, 0, 0, 0, 2, 11'h400, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int sel, e;
      bit [10:0] m;
      sel = $urandom_range(0, 9);
      e = $urandom_range(0, 39) - 24;
      m = {1'b1, 10'($urandom)};
      case (sel)
        0: op(0, 1, 0, 0, 1'($urandom), e, m, 0, 0);
        1: op(0, 0, 0, 1, 1, 0, 0, 0, 0);
        2: op(0, 0, 1, 0, 0, 0, 0, 0, 0);
        3: op(0, 0, 0, 0, 1'($urandom), 0, 0, 0, 0);
        4: op(1, 0, 0, 0, 1, e, m, 0, 0);
        default: op(1, 0, 0, 0, 0, e, m, 0, 0);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sqrt_core.md
# sqrt_core

Iterative square-root stage that consumes the normalize stage's output: unpacked sign, unbiased signed exponent, 11-bit mantissa with explicit leading one, and class flags. It resolves special operands, halves the exponent, and extracts a 12-bit root mantissa, one bit per cycle, with a restoring digit-recurrence. It feeds the downstream round/pack stage with an unrounded root, a guard bit and a sticky bit. It holds one operation at a time; `busy` reports occupancy.

## Interface
- `ITER`, 12: root bits produced; fixed, not user-tunable (radicand width = 2*ITER).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: stall when low; FSM and datapath hold, `r_valid` forced 0.
- `n_valid` in 1: operand valid strobe from normalize.
- `is_num`, `is_nan`, `is_pinf`, `is_ninf` in 1 each: operand class.
- `sign_in` in 1; `exp_in` in 7 signed: unbiased exponent; `mant_in` in 11: 1.10 mantissa.
- `busy` out 1: high from the accept edge until the edge that retires the result.
- `r_valid` out 1: one-cycle result strobe.
- `res_nan`, `res_inf`, `res_zero`, `res_sign` out 1 each.
- `res_exp` out 7 signed: result unbiased exponent.
- `res_mant` out 12: [11] hidden one, [10:1] fraction, [0] guard.
- `res_sticky` out 1: nonzero final remainder.
- `overrun` out 1: sticky; an `n_valid` arrived while busy.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, `enable` and `n_valid` high: latch operand, assert `busy`, classify.
  - NaN result: `is_nan`, `is_ninf`, or (`is_num` and `sign_in`=1). Go to DONE with `res_nan`=1, `res_sign`=0.
  - Infinity: `is_pinf`. Go to DONE with `res_inf`=1, `res_sign`=0.
  - Zero: no flag set. Go to DONE with `res_zero`=1, `res_sign`=`sign_in` (sqrt(-0) = -0).
  - Number, exponent even: radicand R = `mant_in`<<12, e' = `exp_in`.
  - Number, exponent odd: R = `mant_in`<<13, e' = `exp_in`-1.
  - For a number, clear rem (14 b) and q (12 b), load a count of ITER, go to CALC.
- Special and zero results drive `res_exp`, `res_mant` and `res_sticky` to 0.
- CALC, each enabled cycle:
  - trial = {rem, R[23:22]} − {q, 2'b01}.
  - trial ≥ 0: rem ← trial, q ← {q,1}. Otherwise rem ← {rem, R[23:22]}, q ← {q,0}.
  - R ← R<<2; count decrements.
  - After the ITER-th iteration go to DONE.
- Number results:
  - `res_exp` = e'>>>1 (arithmetic). Range is −12..+7 for inputs −24..+15.
  - `res_mant` = q; q[11] is always 1.
  - `res_sticky` = (rem ≠ 0).
- DONE, `enable` high: `r_valid`=1 for that cycle, then IDLE with `busy`=0 at the following edge.
- `n_valid` while busy: operand ignored, `overrun` set. It is cleared only by `rst`.
- `n_valid` is not accepted in the DONE cycle.
- `enable` low in any state: all state frozen, `r_valid`=0. The DONE result is held until an enabled cycle retires it.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `r_valid`, `res_nan`, `res_inf`, `res_zero`, `res_sign`, `res_sticky`, `overrun` = 0.
  - `res_exp`, `res_mant` = 0.
- `rst` mid-CALC or mid-DONE: operation discarded, no `r_valid` is ever produced for it.
- Latency, with `enable` held high and the operand accepted at edge 0:
  - Number: CALC spans edges 1..12, DONE is the cycle after edge 12, so `r_valid` is high between edges 12 and 13.
  - Special/zero: `r_valid` is high between edges 0 and 1.
- Result fields stay valid and stable from the `r_valid` cycle until the next accept.
- Throughput: one operation per 14 cycles for numbers, 2 cycles for specials.

## Configuration
- `SQRT_FIXED_LATENCY_EN` defined: special and zero operands also pass through 12 CALC cycles, with the datapath idle and results preloaded. Every result is then returned 13 cycles after accept, so downstream needs no reorder logic.
- Undefined: special and zero operands bypass CALC (2-cycle occupancy) as described above.

## Test plan
- 4.0 (`exp_in`=2, `mant_in`=0x400) → `res_exp`=1, `res_mant`=0x800, `res_sticky`=0, `r_valid` 13 cycles after accept.
- 2.0 (`exp_in`=1, `mant_in`=0x400) → `res_exp`=0, `res_mant`=0xB50, `res_sticky`=1.
- −1.0 (`is_num`=1, `sign_in`=1) → `res_nan`=1; then `is_pinf` → `res_inf`=1; then −0 → `res_zero`=1, `res_sign`=1. Each completes in 1 cycle without the macro and in 13 with it.
- Second `n_valid` 3 cycles after accepting 9.0 (`exp_in`=3, `mant_in`=0x480) → first result `res_exp`=1, `res_mant`=0xC00, `res_sticky`=0; second operand dropped; `overrun`=1.
- `enable` low for 5 cycles during CALC → `r_valid` delayed exactly 5 cycles, result unchanged. `enable` low during DONE → result held until re-enabled.
- `rst` pulsed at CALC iteration 6 → `busy`=0 next cycle, no `r_valid`, all outputs 0; a fresh operand after reset completes normally.
